ioexp_host: RTL and testbench



---
 rtl/ioexp_host_if.sv | 33 +++
 rtl/ioexp_host.sv | 206 ++++++++++++++++++++
 tb/tb_ioexp_host.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ioexp_host_if.sv
// ioexp_host_if: command/response handshake plus the 8243-style nibble bus
// (p2 + prog_n) seen by the ioexp_host initiator.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_op/cmd_port/cmd_data must be stable while
// cmd_valid is high. The response is a single-cycle rsp_valid pulse with no
// back-pressure; rsp_data/rsp_err are meaningful in that cycle and hold after.
interface ioexp_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_port;
  logic [3:0] cmd_data;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       prog_n;
  logic [3:0] p2o;
  logic       p2_oe;
  logic [3:0] p2i;

  // Host (bus initiator) view.
  modport master (
    input  cmd_valid, cmd_op, cmd_port, cmd_data, p2i,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, prog_n, p2o, p2_oe
  );

  // Environment view: command source, response sink and expander responder.
  modport slave (
    output cmd_valid, cmd_op, cmd_port, cmd_data, p2i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, prog_n, p2o, p2_oe
  );
endinterface

// File: rtl/ioexp_host.sv
// ioexp_host: 8243-style I/O-expander bus initiator. One command runs one
// PROG-strobed cycle: address nibble {op,port} before/at the prog_n fall,
// then operand (write/OR/AND) or bus release and capture (read).
// Optional feature macro: IOEXP_HOST_RMW_EN -- when defined OR/AND run full
// bus cycles; when undefined they are answered at once with rsp_err = 1.
module ioexp_host #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned ADDR_HOLD_CYC = 1,
  parameter int unsigned PROG_LOW_CYC  = 4,
  parameter int unsigned RECOVERY_CYC  = 2
) (
  input  logic         clk,
  input  logic         nrst,
  ioexp_host_if.master bus,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_PROG_LO = 2'd2,
    ST_REC     = 2'd3
  } state_t;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PROG_LD  = 8'(PROG_LOW_CYC - 1);
  localparam logic [7:0] REC_LD   = 8'(RECOVERY_CYC - 1);
  // In PROG_LO the address stays on the bus while the counter is >= this.
  localparam logic [7:0] HOLD_THR = 8'(PROG_LOW_CYC - ADDR_HOLD_CYC);
  localparam logic [1:0] OP_READ  = 2'b00;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_op, w_op;
  logic [1:0] r_port, w_port;
  logic [3:0] r_data, w_data;
  logic [3:0] r_rd_data;
  logic       w_capture;
  logic       w_reject;
  logic       w_is_read;
  logic [3:0] w_addr;

  logic       r_prog_n, w_prog_n_nxt;
  logic       r_p2_oe, w_p2_oe_nxt;
  logic [3:0] r_p2o, w_p2o_nxt;
  logic       r_rsp_valid, w_rsp_valid_nxt;
  logic [3:0] r_rsp_data, w_rsp_data_nxt;
  logic       r_rsp_err, w_rsp_err_nxt;

`ifdef IOEXP_HOST_RMW_EN
  assign w_reject = 1'b0;
`else
  // Without read-modify-write support, OR (10) and AND (11) are refused.
  assign w_reject = bus.cmd_op[1];
`endif

  assign w_is_read = (w_op == OP_READ);
  assign w_addr    = {w_op, w_port};

  // Next-state, phase counter, command latch and response values.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_op            = r_op;
    w_port          = r_port;
    w_data          = r_data;
    w_capture       = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_op   = bus.cmd_op;
          w_port = bus.cmd_port;
          w_data = bus.cmd_data;
          if (w_reject) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = 4'h0;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = SETUP_LD;
          end
        end
      end
      ST_ADDR: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_PROG_LO;
          w_cnt_nxt   = PROG_LD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_PROG_LO: begin
        if (r_cnt == 8'd0) begin
          // This edge raises prog_n; a read samples the responder here.
          w_state_nxt = ST_REC;
          w_cnt_nxt   = REC_LD;
          w_capture   = (r_op == OP_READ);
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_REC: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = (r_op == OP_READ) ? r_rd_data : 4'h0;
          w_rsp_err_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus pin values for the coming cycle, decoded from next state/count.
  always_comb begin
    w_prog_n_nxt = 1'b1;
    w_p2_oe_nxt  = 1'b0;
    w_p2o_nxt    = r_p2o;
    case (w_state_nxt)
      ST_ADDR: begin
        w_p2_oe_nxt = 1'b1;
        w_p2o_nxt   = w_addr;
      end
      ST_PROG_LO: begin
        w_prog_n_nxt = 1'b0;
        if (w_cnt_nxt >= HOLD_THR) begin
          w_p2_oe_nxt = 1'b1;
          w_p2o_nxt   = w_addr;
        end else if (!w_is_read) begin
          w_p2_oe_nxt = 1'b1;
          w_p2o_nxt   = w_data;
        end
      end
      ST_REC: begin
        if (!w_is_read) begin
          w_p2_oe_nxt = 1'b1;
          w_p2o_nxt   = w_data;
        end
      end
      default: begin
      end
    endcase
  end

  // State, counter and latched command.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_op    <= 2'b00;
      r_port  <= 2'b00;
      r_data  <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op;
      r_port  <= w_port;
      r_data  <= w_data;
    end
  end

  // Read nibble capture on the prog_n rising edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_data <= 4'h0;
    end else if (w_capture) begin
      r_rd_data <= bus.p2i;
    end
  end

  // Registered bus pins and response; reset releases the bus immediately.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_prog_n    <= 1'b1;
      r_p2_oe     <= 1'b0;
      r_p2o       <= 4'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 4'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_prog_n    <= w_prog_n_nxt;
      r_p2_oe     <= w_p2_oe_nxt;
      r_p2o       <= w_p2o_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.prog_n    = r_prog_n;
  assign bus.p2_oe     = r_p2_oe;
  assign bus.p2o       = r_p2o;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ioexp_host.sv
// tb_ioexp_host: directed bench for ioexp_host with default timing
// parameters (setup 2, hold 1, prog low 4, recovery 2).
module tb_ioexp_host;

  logic       clk;
  logic       nrst;
  logic [1:0] dbg_state;
  logic [3:0] resp_nib;
  int         errors;
  int         checks;

  ioexp_host_if bus();

  ioexp_host #(
    .SETUP_CYC(2), .ADDR_HOLD_CYC(1), .PROG_LOW_CYC(4), .RECOVERY_CYC(2)
  ) u_dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // Expander responder: drives its nibble only while strobed and the host is off the bus.
  assign bus.p2i = (!bus.p2_oe && !bus.prog_n) ? resp_nib : 4'h0;

  // Clock: ~7.37 MHz.
  initial begin
    clk = 1'b0;
    forever #68 clk = ~clk;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         t_fall;
    int         t_rise;
    int         t_rsp;
    logic [3:0] addr_seen;
    logic [3:0] hold_seen;
    logic [3:0] opnd_seen;
    int         oe_cnt;
    int         oe_low;
    int         busy_cnt;
    logic [3:0] rsp_d;
    logic       rsp_e;
  } obs_t;

  // Driver: present one command (accepted at the next posedge), then watch
  // the bus each negedge. Cycle j = j-th cycle after the accept edge.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] port,
                         input logic [3:0] data, output obs_t o);
    int j;
    o.t_fall = -1; o.t_rise = -1; o.t_rsp = -1;
    o.addr_seen = 4'h0; o.hold_seen = 4'h0; o.opnd_seen = 4'h0;
    o.oe_cnt = 0; o.oe_low = 0; o.busy_cnt = 0;
    o.rsp_d = 4'h0; o.rsp_e = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_port  = port;
    bus.cmd_data  = data;
    @(posedge clk);
    j = 0;
    while (o.t_rsp < 0 && j < 40) begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        bus.cmd_valid = 1'b0;
        o.addr_seen = bus.p2o;
      end
      if (!bus.prog_n && o.t_fall < 0) begin
        o.t_fall = j;
        o.hold_seen = bus.p2o;
      end
      if (bus.prog_n && o.t_fall >= 0 && o.t_rise < 0) o.t_rise = j;
      if (o.t_fall >= 0 && j == o.t_fall + 1) o.opnd_seen = bus.p2o;
      if (bus.p2_oe) o.oe_cnt++;
      if (bus.p2_oe && !bus.prog_n) o.oe_low++;
      if (!bus.cmd_ready) o.busy_cnt++;
      if (bus.rsp_valid) begin
        o.t_rsp = j;
        o.rsp_d = bus.rsp_data;
        o.rsp_e = bus.rsp_err;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.prog_n !== 1'b1) begin errors++; $display("FAIL reset_prog_n: got %b expected 1", bus.prog_n); end
    checks++; if (bus.p2_oe !== 1'b0) begin errors++; $display("FAIL reset_p2_oe: got %b expected 0", bus.p2_oe); end
    checks++; if (bus.p2o !== 4'h0) begin errors++; $display("FAIL reset_p2o: got %h expected 0", bus.p2o); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err} !== 6'b0) begin errors++; $display("FAIL reset_rsp: got v=%b d=%h e=%b expected all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    obs_t o;
    run_cmd(2'b01, 2'b01, 4'hA, o);
    checks++; if (o.addr_seen !== 4'h5) begin errors++; $display("FAIL write_addr: got %h expected 5", o.addr_seen); end
    checks++; if (o.hold_seen !== 4'h5) begin errors++; $display("FAIL write_addr_hold: got %h expected 5", o.hold_seen); end
    checks++; if (o.opnd_seen !== 4'hA) begin errors++; $display("FAIL write_operand: got %h expected a", o.opnd_seen); end
    checks++; if (o.t_fall !== 3) begin errors++; $display("FAIL write_prog_fall: got %0d expected 3", o.t_fall); end
    checks++; if (o.t_rise - o.t_fall !== 4) begin errors++; $display("FAIL write_prog_low_len: got %0d expected 4", o.t_rise - o.t_fall); end
    checks++; if (o.t_rsp !== 9) begin errors++; $display("FAIL write_rsp_time: got %0d expected 9", o.t_rsp); end
    checks++; if (o.rsp_d !== 4'h0 || o.rsp_e !== 1'b0) begin errors++; $display("FAIL write_rsp: got d=%h e=%b expected d=0 e=0", o.rsp_d, o.rsp_e); end
    checks++; if (o.oe_cnt !== 8) begin errors++; $display("FAIL write_oe_cycles: got %0d expected 8", o.oe_cnt); end
    checks++; if (o.busy_cnt !== 8) begin errors++; $display("FAIL write_busy_cycles: got %0d expected 8", o.busy_cnt); end
  endtask

  task automatic test_read();
    obs_t o;
    resp_nib = 4'hC;
    run_cmd(2'b00, 2'b11, 4'h0, o);
    checks++; if (o.addr_seen !== 4'h3) begin errors++; $display("FAIL read_addr: got %h expected 3", o.addr_seen); end
    checks++; if (o.t_fall !== 3 || o.t_rise !== 7) begin errors++; $display("FAIL read_strobe: got fall=%0d rise=%0d expected 3/7", o.t_fall, o.t_rise); end
    checks++; if (o.oe_cnt !== 3 || o.oe_low !== 1) begin errors++; $display("FAIL read_turnaround: got oe=%0d oe_low=%0d expected 3/1", o.oe_cnt, o.oe_low); end
    checks++; if (o.t_rsp !== 9) begin errors++; $display("FAIL read_rsp_time: got %0d expected 9", o.t_rsp); end
    checks++; if (o.rsp_d !== 4'hC || o.rsp_e !== 1'b0) begin errors++; $display("FAIL read_rsp: got d=%h e=%b expected d=c e=0", o.rsp_d, o.rsp_e); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 4'hC) begin errors++; $display("FAIL read_rsp_hold: got v=%b d=%h expected v=0 d=c", bus.rsp_valid, bus.rsp_data); end
  endtask

  task automatic test_rmw();
    obs_t o;
    run_cmd(2'b11, 2'b00, 4'h3, o);
`ifdef IOEXP_HOST_RMW_EN
    checks++; if (o.addr_seen !== 4'hC) begin errors++; $display("FAIL and_addr: got %h expected c", o.addr_seen); end
    checks++; if (o.t_fall !== 3 || o.t_rise !== 7) begin errors++; $display("FAIL and_strobe: got fall=%0d rise=%0d expected 3/7", o.t_fall, o.t_rise); end
    checks++; if (o.opnd_seen !== 4'h3) begin errors++; $display("FAIL and_operand: got %h expected 3", o.opnd_seen); end
    checks++; if (o.t_rsp !== 9 || o.rsp_e !== 1'b0 || o.rsp_d !== 4'h0) begin errors++; $display("FAIL and_rsp: got t=%0d e=%b d=%h expected t=9 e=0 d=0", o.t_rsp, o.rsp_e, o.rsp_d); end
`else
    checks++; if (o.t_rsp !== 1) begin errors++; $display("FAIL and_reject_time: got %0d expected 1", o.t_rsp); end
    checks++; if (o.rsp_e !== 1'b1 || o.rsp_d !== 4'h0) begin errors++; $display("FAIL and_reject_rsp: got e=%b d=%h expected e=1 d=0", o.rsp_e, o.rsp_d); end
    checks++; if (o.t_fall !== -1 || o.oe_cnt !== 0) begin errors++; $display("FAIL and_reject_bus: got fall=%0d oe=%0d expected -1/0", o.t_fall, o.oe_cnt); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.prog_n !== 1'b1) begin errors++; $display("FAIL and_reject_pulse: got v=%b prog_n=%b expected 0/1", bus.rsp_valid, bus.prog_n); end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    obs_t o1;
    obs_t o2;
    resp_nib = 4'h6;
    run_cmd(2'b01, 2'b10, 4'h9, o1);
    run_cmd(2'b00, 2'b00, 4'h0, o2);
    checks++; if (o1.t_rsp !== 9 || o1.rsp_e !== 1'b0) begin errors++; $display("FAIL b2b_write_rsp: got t=%0d e=%b expected t=9 e=0", o1.t_rsp, o1.rsp_e); end
    checks++; if (o2.addr_seen !== 4'h0 || o2.t_fall !== 3) begin errors++; $display("FAIL b2b_read_start: got addr=%h fall=%0d expected 0/3", o2.addr_seen, o2.t_fall); end
    checks++; if (9 + o2.t_fall - o1.t_rise !== 5) begin errors++; $display("FAIL b2b_strobe_gap: got %0d expected 5", 9 + o2.t_fall - o1.t_rise); end
    checks++; if (o2.t_rsp !== 9 || o2.rsp_d !== 4'h6) begin errors++; $display("FAIL b2b_read_rsp: got t=%0d d=%h expected t=9 d=6", o2.t_rsp, o2.rsp_d); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   rsp_seen;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_port  = 2'b01;
    bus.cmd_data  = 4'h7;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.prog_n !== 1'b0 || bus.p2_oe !== 1'b1) begin errors++; $display("FAIL abort_in_prog_lo: got prog_n=%b oe=%b expected 0/1", bus.prog_n, bus.p2_oe); end
    #10;
    nrst = 1'b0;
    #1;
    checks++; if (bus.prog_n !== 1'b1 || bus.p2_oe !== 1'b0) begin errors++; $display("FAIL abort_release: got prog_n=%b oe=%b expected 1/0", bus.prog_n, bus.p2_oe); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", bus.cmd_ready); end
    @(negedge clk);
    nrst = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || !bus.prog_n) rsp_seen++;
    end
    checks++; if (rsp_seen !== 0) begin errors++; $display("FAIL abort_no_rsp: got %0d active cycles expected 0", rsp_seen); end
    run_cmd(2'b01, 2'b00, 4'h2, o);
    checks++; if (o.addr_seen !== 4'h4 || o.opnd_seen !== 4'h2) begin errors++; $display("FAIL post_abort_bus: got addr=%h opnd=%h expected 4/2", o.addr_seen, o.opnd_seen); end
    checks++; if (o.t_fall !== 3 || o.t_rise !== 7 || o.t_rsp !== 9) begin errors++; $display("FAIL post_abort_timing: got %0d/%0d/%0d expected 3/7/9", o.t_fall, o.t_rise, o.t_rsp); end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    nrst          = 1'b0;
    resp_nib      = 4'h0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_port  = 2'b00;
    bus.cmd_data  = 4'h0;
    test_reset();
    test_write();
    test_read();
    test_rmw();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
